// File: rtl/tt_btn_ctrl_if.sv
// tt_btn_ctrl_if: groups the button-conditioning signals between the board
// side (raw buttons in) and the consumer side (debounced levels, press
// pulses and the run/speed control registers).
//
// Signals:
//   btn_in      [2:0]          raw asynchronous buttons: [0] pause, [1] faster, [2] slower
//   btn_state   [2:0]          debounced button levels
//   press_pulse [2:0]          one-cycle pulse per debounced 0->1 transition
//   run                        1 = pattern advancing, 0 = paused
//   speed       [SPEED_W-1:0]  current speed level, 0 = slowest
//
// Modports:
//   master - drives btn_in, observes the conditioned outputs (board / bench)
//   slave  - the conditioning block itself
//
// Handshake: there is no valid/ready pairing here. btn_in is a free-running
// asynchronous level. press_pulse is a single-cycle strobe that the consumer
// must sample on the clock edge where it is high; it cannot be back-pressured.
interface tt_btn_ctrl_if #(
  parameter int SPEED_W = 3
);
  logic [2:0]         btn_in;
  logic [2:0]         btn_state;
  logic [2:0]         press_pulse;
  logic               run;
  logic [SPEED_W-1:0] speed;

  modport master (
    output btn_in,
    input  btn_state,
    input  press_pulse,
    input  run,
    input  speed
  );

  modport slave (
    input  btn_in,
    output btn_state,
    output press_pulse,
    output run,
    output speed
  );
endinterface

// File: rtl/tt_btn_ctrl.sv
// tt_btn_ctrl: input-conditioning and control stage in front of the
// running-light core. Each of the three push-buttons is synchronised with a
// 2-FF chain, debounced by a stability counter, and turned into a one-cycle
// press pulse. The block also owns the run/pause flag and the saturating
// speed level that the core consumes.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   tt_btn_ctrl_if.slave: btn_in in; btn_state, press_pulse, run,
//         speed out (all outputs registered, no combinational path from btn_in)
module tt_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int SPEED_W         = 3,
  parameter int SPEED_MAX       = 7,
  parameter int SPEED_RESET     = 3
) (
  input  logic          clk,
  input  logic          rst,
  tt_btn_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SPEED_W-1:0] SPD_MAX   = SPEED_W'(SPEED_MAX);
  localparam logic [SPEED_W-1:0] SPD_RST   = SPEED_W'(SPEED_RESET);
  localparam logic [SPEED_W-1:0] SPD_ONE   = SPEED_W'(1);
  localparam logic [SPEED_W-1:0] SPD_ZERO  = '0;

  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         stable_q, stable_d;
  logic [2:0]         pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q [3];
  logic [CNT_W-1:0]   cnt_d [3];
  logic               run_q, run_d;
  logic [SPEED_W-1:0] speed_q, speed_d;

  // Debounce: the counter only runs while the synchronised input disagrees
  // with the accepted level; any return to agreement restarts it, so a glitch
  // must persist DEBOUNCE_CYCLES consecutive cycles to be accepted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    // Pulse is registered at the same edge the level is accepted as high.
    pulse_d = stable_d & ~stable_q;
  end

  // Control registers act on the registered pulses, one edge after them.
  always_comb begin
    run_d   = run_q ^ pulse_q[0];
    speed_d = speed_q;
    case (pulse_q[2:1])
      2'b01: if (speed_q != SPD_MAX)  speed_d = speed_q + SPD_ONE;
      2'b10: if (speed_q != SPD_ZERO) speed_d = speed_q - SPD_ONE;
      default: speed_d = speed_q;  // none, or faster+slower cancel
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      pulse_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      run_q    <= 1'b0;
      speed_q  <= SPD_RST;
    end else begin
      sync1_q  <= bus.btn_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      run_q    <= run_d;
      speed_q  <= speed_d;
    end
  end

  assign bus.btn_state   = stable_q;
  assign bus.press_pulse = pulse_q;
  assign bus.run         = run_q;
  assign bus.speed       = speed_q;

endmodule

// File: tb/tb_tt_btn_ctrl.sv
module tb_tt_btn_ctrl;

  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  tt_btn_ctrl_if #(.SPEED_W(3)) bus_if ();

  tt_btn_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(20),
    .SPEED_W(3),
    .SPEED_MAX(7),
    .SPEED_RESET(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- model + scoreboard ----------------
  // Entry: {pulse[2:0], run after pulse, speed after pulse}
  logic [6:0] exp_q[$];
  logic       exp_run   = 1'b0;
  logic [2:0] exp_speed = 3'd3;

  logic       pending = 1'b0;
  logic [2:0] pend_pulse = 3'b000;

  // Monitor: capture a pulse, then one cycle later read run/speed and
  // compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        logic [6:0] act;
        logic [6:0] exp;
        act = {pend_pulse, bus_if.run, bus_if.speed};
        checks++;
        if (bus_if.press_pulse !== 3'b000) begin
          errors++;
          $display("FAIL pulse_width: press_pulse=%b one cycle after %b, required 000",
                   bus_if.press_pulse, pend_pulse);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got {pulse,run,speed}=%b, none expected", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL pulse_effect: got {pulse,run,speed}=%b, required %b", act, exp);
          end
        end
        pending = 1'b0;
      end else if (bus_if.press_pulse !== 3'b000) begin
        pend_pulse = bus_if.press_pulse;
        pending    = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_press(input logic [2:0] bits);
    exp_run = exp_run ^ bits[0];
    if (bits[2:1] == 2'b01 && exp_speed != 3'd7) exp_speed = exp_speed + 3'd1;
    if (bits[2:1] == 2'b10 && exp_speed != 3'd0) exp_speed = exp_speed - 3'd1;
    exp_q.push_back({bits, exp_run, exp_speed});
  endtask

  task automatic drive_press(input logic [2:0] bits, input int hold);
    expect_press(bits);
    @(negedge clk);
    bus_if.btn_in = bits;
    repeat (hold) @(negedge clk);
    bus_if.btn_in = 3'b000;
    repeat (15) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      bus_if.btn_in = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    checks++;
    if ({bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed} !== {3'b000, 3'b000, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL reset_hold: state=%b pulse=%b run=%b speed=%0d, required 000 000 0 3",
               bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed);
    end
    bus_if.btn_in = 3'b000;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if ({bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed} !== {3'b000, 3'b000, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL reset_idle: state=%b pulse=%b run=%b speed=%0d, required 000 000 0 3",
               bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed);
    end
  endtask

  task automatic test_pause;
    expect_press(3'b001);
    @(negedge clk);
    bus_if.btn_in = 3'b001;
    // n counts rising edges from the first one that samples the button.
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      checks++;
      if (bus_if.press_pulse[0] !== (n == 6)) begin
        errors++;
        $display("FAIL pause_pulse_timing: edge %0d press_pulse[0]=%b, required %b",
                 n, bus_if.press_pulse[0], (n == 6));
      end
      if (n == 6) begin
        checks++;
        if (bus_if.btn_state[0] !== 1'b1) begin
          errors++;
          $display("FAIL pause_state: btn_state[0]=%b, required 1", bus_if.btn_state[0]);
        end
      end
      if (n == 7) begin
        checks++;
        if (bus_if.run !== 1'b1) begin
          errors++;
          $display("FAIL pause_run: run=%b, required 1", bus_if.run);
        end
      end
    end
    repeat (8) @(negedge clk);
    bus_if.btn_in = 3'b000;
    repeat (15) @(negedge clk);
    checks++;
    if (bus_if.btn_state[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_release: btn_state[0]=%b, required 0", bus_if.btn_state[0]);
    end
    drive_press(3'b001, 15);
    checks++;
    if (bus_if.run !== 1'b0) begin
      errors++;
      $display("FAIL pause_second: run=%b, required 0", bus_if.run);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pause_missing: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch;
    @(negedge clk);
    bus_if.btn_in = 3'b010;
    repeat (3) @(negedge clk);
    bus_if.btn_in = 3'b000;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if (bus_if.btn_state[1] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_state: cycle %0d btn_state[1]=%b, required 0", n, bus_if.btn_state[1]);
      end
    end
    checks++;
    if (bus_if.speed !== 3'd3) begin
      errors++;
      $display("FAIL glitch_speed: speed=%0d, required 3", bus_if.speed);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 6; i++) drive_press(3'b010, 8 + int'($urandom_range(0, 7)));
    checks++;
    if (bus_if.speed !== 3'd7) begin
      errors++;
      $display("FAIL sat_high: speed=%0d, required 7", bus_if.speed);
    end
    for (int i = 0; i < 9; i++) drive_press(3'b100, 8 + int'($urandom_range(0, 7)));
    checks++;
    if (bus_if.speed !== 3'd0) begin
      errors++;
      $display("FAIL sat_low: speed=%0d, required 0", bus_if.speed);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sat_missing: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous;
    drive_press(3'b110, 15);
    checks++;
    if (bus_if.speed !== 3'd0 || bus_if.run !== 1'b0) begin
      errors++;
      $display("FAIL simul_effect: run=%b speed=%0d, required 0 0", bus_if.run, bus_if.speed);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_missing: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_debounce;
    @(negedge clk);
    bus_if.btn_in = 3'b001;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed} !== {3'b000, 3'b000, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL mid_reset: state=%b pulse=%b run=%b speed=%0d, required 000 000 0 3",
               bus_if.btn_state, bus_if.press_pulse, bus_if.run, bus_if.speed);
    end
    exp_run   = 1'b0;
    exp_speed = 3'd3;
    expect_press(3'b001);
    rst = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      checks++;
      if (bus_if.press_pulse[0] !== (n == 6)) begin
        errors++;
        $display("FAIL mid_pulse_timing: edge %0d press_pulse[0]=%b, required %b",
                 n, bus_if.press_pulse[0], (n == 6));
      end
    end
    checks++;
    if (bus_if.run !== 1'b1) begin
      errors++;
      $display("FAIL mid_run: run=%b, required 1", bus_if.run);
    end
    repeat (20) @(negedge clk);
    bus_if.btn_in = 3'b000;
    repeat (15) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_missing: %0d expected pulses not seen, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus_if.btn_in = 3'b000;
    test_reset();
    test_pause();
    test_glitch();
    test_saturation();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
